// File: rtl/cmul_arbiter_if.sv
// Requester/consumer bundle for the shared complex multiplier.
// The arbiter takes the slave side; the requesters and consumer the master side.
interface cmul_arbiter_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       i_req_valid;
    logic [63:0]      i_req_a;
    logic [63:0]      i_req_b;
    logic [3:0]       o_req_ready;
    logic             o_res_valid;
    logic [15:0]      o_res_data;
    logic [1:0]       o_res_id;
    logic             i_res_ready;
    logic             o_busy;
    logic [CNT_W-1:0] o_done_cnt;

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_res_ready,
        output o_req_ready, o_res_valid, o_res_data, o_res_id,
        output o_busy, o_done_cnt
    );

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_res_ready,
        input  o_req_ready, o_res_valid, o_res_data, o_res_id,
        input  o_busy, o_done_cnt
    );
endinterface

// File: rtl/cmul_arbiter.sv
// Four requesters share one 8-bit complex multiplier through a
// round-robin grant and a two-stage pipeline with result backpressure.
module cmul_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    cmul_arbiter_if.slave bus
);
    logic [1:0]       last_grant_q, last_grant_d;
    logic             s1_valid_q, s1_valid_d;
    logic [15:0]      s1_a_q, s1_a_d;
    logic [15:0]      s1_b_q, s1_b_d;
    logic [1:0]       s1_id_q, s1_id_d;
    logic             s2_valid_q, s2_valid_d;
    logic [15:0]      s2_data_q, s2_data_d;
    logic [1:0]       s2_id_q, s2_id_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    logic       stall;
    logic       found;
    logic [1:0] gid;
    logic [3:0] grant;
    logic [7:0] prod_re;
    logic [7:0] prod_im;

    assign stall = s2_valid_q & ~bus.i_res_ready;

    // Search upward from the slot after the last winner; reset blocks grants.
    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        gid   = last_grant_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant_q + 2'(k);
            if (!found && bus.i_req_valid[idx]) begin
                found = 1'b1;
                gid   = idx;
            end
        end
        if (stall || i_rst) begin
            found = 1'b0;
        end
        grant = found ? (4'b0001 << gid) : 4'b0000;
    end

    // Products are taken modulo 256; the 8-bit context drops the carries.
    assign prod_re = s1_a_q[15:8] * s1_b_q[15:8] - s1_a_q[7:0] * s1_b_q[7:0];
    assign prod_im = s1_a_q[15:8] * s1_b_q[7:0] + s1_a_q[7:0] * s1_b_q[15:8];

    always_comb begin
        last_grant_d = last_grant_q;
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_id_d      = s1_id_q;
        s2_valid_d   = s2_valid_q;
        s2_data_d    = s2_data_q;
        s2_id_d      = s2_id_q;
        done_cnt_d   = done_cnt_q;
        if (!stall) begin
            s1_valid_d = found;
            s1_a_d     = bus.i_req_a[{gid, 4'b0000} +: 16];
            s1_b_d     = bus.i_req_b[{gid, 4'b0000} +: 16];
            s1_id_d    = gid;
            s2_valid_d = s1_valid_q;
            s2_data_d  = {prod_re, prod_im};
            s2_id_d    = s1_id_q;
            if (found) begin
                last_grant_d = gid;
            end
        end
        if (s2_valid_q && bus.i_res_ready) begin
            done_cnt_d = done_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant_q <= 2'd3;
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_id_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_id_q      <= '0;
            done_cnt_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_id_q      <= s1_id_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_id_q      <= s2_id_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

    assign bus.o_req_ready = grant;
    assign bus.o_res_valid = s2_valid_q;
    assign bus.o_res_data  = s2_data_q;
    assign bus.o_res_id    = s2_id_q;
    assign bus.o_busy      = s1_valid_q | s2_valid_q;
    assign bus.o_done_cnt  = done_cnt_q;
endmodule

// File: tb/tb_cmul_arbiter.sv
// Scoreboard bench for cmul_arbiter: transfers push expected results,
// handoffs pop and compare them.
module tb_cmul_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    cmul_arbiter_if #(.CNT_W(8)) bus ();

    cmul_arbiter #(.CNT_W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cmul(input logic [15:0] a,
                                         input logic [15:0] b);
        int ar, ai, br, bi, re, im;
        ar = int'(a[15:8]);
        ai = int'(a[7:0]);
        br = int'(b[15:8]);
        bi = int'(b[7:0]);
        re = (ar * br - ai * bi) & 255;
        im = (ar * bi + ai * br) & 255;
        return {re[7:0], im[7:0]};
    endfunction

    logic [17:0] sb[$];
    logic [1:0]  mlast = 2'd3;
    int          mcnt = 0;

    // Reference grant model and scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [3:0]  exp_rdy;
        logic [1:0]  idx;
        logic [17:0] e;
        if (rst) begin
            chk("rst_ready", 32'(bus.o_req_ready), 0);
            chk("rst_res_valid", 32'(bus.o_res_valid), 0);
            chk("rst_busy", 32'(bus.o_busy), 0);
            chk("rst_cnt", 32'(bus.o_done_cnt), 0);
            sb.delete();
            mlast = 2'd3;
            mcnt = 0;
        end else begin
            exp_rdy = 4'b0000;
            if (!(bus.o_res_valid && !bus.i_res_ready)) begin
                for (int k = 1; k <= 4; k++) begin
                    idx = mlast + 2'(k);
                    if (exp_rdy == 4'b0000 && bus.i_req_valid[idx])
                        exp_rdy = 4'b0001 << idx;
                end
            end
            chk("grant", 32'(bus.o_req_ready), 32'(exp_rdy));
            chk("done_cnt", 32'(bus.o_done_cnt), 32'(mcnt & 255));
            if (bus.o_res_valid && bus.i_res_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_result", 32'({bus.o_res_id, bus.o_res_data}),
                        32'h3ffff);
                end else begin
                    e = sb.pop_front();
                    chk("result", 32'({bus.o_res_id, bus.o_res_data}),
                        32'(e));
                end
                mcnt++;
            end
            for (int n = 0; n < 4; n++) begin
                if (exp_rdy[n] && bus.i_req_valid[n]) begin
                    sb.push_back({2'(n), cmul(bus.i_req_a[16*n +: 16],
                                              bus.i_req_b[16*n +: 16])});
                    mlast = 2'(n);
                end
            end
        end
    end

    task automatic reset_on();
        @(posedge clk);
        #2 rst = 1'b1;
        bus.i_req_valid = 4'b0000;
        bus.i_res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_off();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        bus.i_req_valid = 4'b0000;
        bus.i_res_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic single(input int n, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp);
        bus.i_req_valid = 4'b0001 << n;
        bus.i_req_a[16*n +: 16] = a;
        bus.i_req_b[16*n +: 16] = b;
        bus.i_res_ready = 1'b1;
        @(negedge clk);
        chk("single_ready", 32'(bus.o_req_ready), 32'(4'b0001 << n));
        @(posedge clk);
        #1 bus.i_req_valid = 4'b0000;
        @(posedge clk);
        #1;
        chk("single_valid", 32'(bus.o_res_valid), 1);
        chk("single_data", 32'(bus.o_res_data), 32'(exp));
        chk("single_id", 32'(bus.o_res_id), n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cnt[4];
        int sent, cyc, nx;
        logic [15:0] ta[6];
        logic [15:0] tb[6];

        bus.i_req_valid = 4'b1111;
        bus.i_req_a = '0;
        bus.i_req_b = '0;
        bus.i_res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(bus.o_req_ready), 0);
        chk("reset_data", 32'(bus.o_res_data), 0);
        chk("reset_id", 32'(bus.o_res_id), 0);
        bus.i_req_valid = 4'b0000;
        reset_off();

        single(0, 16'h0102, 16'h0304, 16'hFB0A);
        single(1, 16'h2000, 16'h0900, 16'h2000);
        single(1, 16'h1010, 16'h1010, 16'h0000);
        drain();

        // Fairness from reset with all requesters asserted.
        reset_on();
        bus.i_req_valid = 4'b1111;
        reset_off();
        cnt = '{0, 0, 0, 0};
        for (int k = 0; k < 100; k++) begin
            bus.i_req_a = {$urandom, $urandom};
            bus.i_req_b = {$urandom, $urandom};
            @(negedge clk);
            chk("rr_order", 32'(bus.o_req_ready), 32'(4'b0001 << (k % 4)));
            for (int n = 0; n < 4; n++)
                if (bus.o_req_ready[n]) cnt[n]++;
            @(posedge clk);
            #1;
        end
        for (int n = 0; n < 4; n++) chk("rr_share", cnt[n], 25);
        drain();

        // Backpressure in the middle of a six-request stream.
        reset_on();
        reset_off();
        for (int k = 0; k < 6; k++) begin
            ta[k] = 16'($urandom);
            tb[k] = 16'($urandom);
        end
        sent = 0;
        cyc = 0;
        while (sent < 6 && cyc < 50) begin
            bus.i_res_ready = !(cyc >= 3 && cyc < 8);
            bus.i_req_valid = 4'b0100;
            bus.i_req_a[47:32] = ta[sent];
            bus.i_req_b[47:32] = tb[sent];
            @(negedge clk);
            if (!bus.i_res_ready)
                chk("bp_stall_ready", 32'(bus.o_req_ready), 0);
            if (bus.o_req_ready[2]) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("bp_sent", sent, 6);
        drain();
        chk("bp_done_cnt", 32'(bus.o_done_cnt), 6);

        // Reset with two entries in flight.
        bus.i_req_valid = 4'b1000;
        bus.i_req_a[63:48] = 16'h1234;
        bus.i_req_b[63:48] = 16'h5678;
        @(posedge clk);
        #1 bus.i_req_a[63:48] = 16'h4321;
        @(posedge clk);
        #1 bus.i_req_valid = 4'b0000;
        chk("inflight_busy", 32'(bus.o_busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_res_valid", 32'(bus.o_res_valid), 0);
        chk("async_busy", 32'(bus.o_busy), 0);
        reset_off();
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(bus.o_busy), 0);

        // Random traffic up to exactly 256 handoffs.
        reset_on();
        reset_off();
        nx = 0;
        cyc = 0;
        while (nx < 256 && cyc < 3000) begin
            bus.i_req_valid = 4'($urandom);
            bus.i_req_a = {$urandom, $urandom};
            bus.i_req_b = {$urandom, $urandom};
            bus.i_res_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            nx += $countones(bus.o_req_ready & bus.i_req_valid);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("wrap_xfers", nx, 256);
        drain();
        chk("wrap_handoffs", mcnt, 256);
        chk("wrap_cnt", 32'(bus.o_done_cnt), 0);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
